// File: rtl/i2c_eeprom_slave_pkg.sv
// Shared definitions for the I2C EEPROM slave: FSM state encoding,
// default device ID, control-byte R/W bit position and block-bit mask helper.
package i2c_eeprom_slave_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV,
        ST_DEV_ACK,
        ST_WADDR,
        ST_WADDR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RACK
    } state_t;

    localparam logic [3:0] DEV_ID_DEFAULT = 4'b1010;
    localparam int         RW_BIT         = 0;

    // Block bits of the control byte that map onto address bits above bit 7.
    function automatic logic [2:0] blk_mask(input int addr_w);
        return 3'((1 << (addr_w - 8)) - 1);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronisers for SCL/SDA plus registered edge, START and STOP detection.
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);
    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_d_q;
    logic       sda_d_q;
    logic       rise_q;
    logic       fall_q;
    logic       start_q;
    logic       stop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_d_q    <= 1'b1;
            sda_d_q    <= 1'b1;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl};
            sda_sync_q <= {sda_sync_q[0], sda_in};
            scl_d_q    <= scl_sync_q[1];
            sda_d_q    <= sda_sync_q[1];
            rise_q     <= scl_sync_q[1] & ~scl_d_q;
            fall_q     <= ~scl_sync_q[1] & scl_d_q;
            start_q    <= scl_sync_q[1] & scl_d_q & sda_d_q & ~sda_sync_q[1];
            stop_q     <= scl_sync_q[1] & scl_d_q & ~sda_d_q & sda_sync_q[1];
        end
    end

    // sda_d_q is aligned with the registered pulses: it holds the SDA value at the SCL edge.
    assign scl_rise  = rise_q;
    assign scl_fall  = fall_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;
    assign sda_s     = sda_d_q;

endmodule

// File: rtl/i2c_eeprom_slave.sv
// I2C serial-EEPROM slave: byte/page write with in-page wrap, current/random/sequential read.
// Optional write-protect input is added by defining I2C_EEPROM_WP_EN.
//   state     | meaning
//   IDLE      | unaddressed, SDA released
//   DEV       | shifting control byte
//   DEV_ACK   | ACKing control byte
//   WADDR(_ACK)| shifting / ACKing low address byte
//   WDATA(_ACK)| shifting / ACKing (or NACKing) a write byte
//   RDATA     | driving read byte
//   RACK      | waiting for master ACK/NACK
module i2c_eeprom_slave
    import i2c_eeprom_slave_pkg::*;
#(
    parameter int         ADDR_W = 11,
    parameter logic [3:0] DEV_ID = DEV_ID_DEFAULT,
    parameter int         PAGE_W = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef I2C_EEPROM_WP_EN
    input  logic wp,
`endif
    input  logic scl,
    input  logic sda_in,
    output logic sda_oe,
    output logic busy
);
    localparam int                MEM_DEPTH = 1 << ADDR_W;
    localparam logic [2:0]        BLK_MASK  = blk_mask(ADDR_W);
    localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'((1 << PAGE_W) - 1);

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_s;

    i2c_line_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    state_t            state_q;
    logic [2:0]        bitcnt_q;
    logic [7:0]        shift_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [2:0]        blk_q;
    logic              rw_q;
    logic              ack_ph_q;
    logic              nack_q;
    logic              sda_oe_q;
    logic [7:0]        mem_q [MEM_DEPTH];

    logic wp_act;
`ifdef I2C_EEPROM_WP_EN
    assign wp_act = wp;
`else
    assign wp_act = 1'b0;
`endif

    logic [7:0]        byte_in;
    logic              last_bit;
    logic              dev_match;
    logic              mem_we;
    logic [ADDR_W-1:0] ptr_nx;
    logic [ADDR_W-1:0] ptr_pg;

    assign byte_in   = {shift_q[6:0], sda_s};
    assign last_bit  = (bitcnt_q == 3'd7);
    assign dev_match = (byte_in[7:4] == DEV_ID) && ((byte_in[3:1] & ~BLK_MASK) == 3'b000);
    assign ptr_nx    = ptr_q + ADDR_W'(1);
    assign ptr_pg    = (ptr_q & ~PAGE_MASK) | (ptr_nx & PAGE_MASK);
    assign mem_we    = ~rst & ~start_det & ~stop_det & scl_rise & (state_q == ST_WDATA)
                     & last_bit & ~wp_act;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[ptr_q] <= byte_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= 3'd0;
            shift_q  <= 8'd0;
            ptr_q    <= '0;
            blk_q    <= 3'd0;
            rw_q     <= 1'b0;
            ack_ph_q <= 1'b0;
            nack_q   <= 1'b0;
            sda_oe_q <= 1'b0;
        end else if (start_det) begin
            state_q  <= ST_DEV;
            bitcnt_q <= 3'd0;
            ack_ph_q <= 1'b0;
            sda_oe_q <= 1'b0;
        end else if (stop_det) begin
            state_q  <= ST_IDLE;
            sda_oe_q <= 1'b0;
        end else if (scl_rise) begin
            case (state_q)
                ST_DEV, ST_WADDR, ST_WDATA, ST_RDATA: begin
                    shift_q  <= byte_in;
                    bitcnt_q <= bitcnt_q + 3'd1;
                    ack_ph_q <= 1'b0;
                    if (last_bit) begin
                        case (state_q)
                            ST_DEV: begin
                                if (dev_match) begin
                                    state_q <= ST_DEV_ACK;
                                    rw_q    <= byte_in[RW_BIT];
                                    blk_q   <= byte_in[3:1];
                                end else begin
                                    state_q <= ST_IDLE;
                                end
                            end
                            ST_WADDR: begin
                                state_q <= ST_WADDR_ACK;
                                ptr_q   <= ADDR_W'({blk_q & BLK_MASK, byte_in});
                            end
                            ST_WDATA: begin
                                state_q <= ST_WDATA_ACK;
                                nack_q  <= wp_act;
                                if (!wp_act) begin
                                    ptr_q <= ptr_pg;
                                end
                            end
                            default: state_q <= ST_RACK;
                        endcase
                    end
                end
                ST_RACK: begin
                    if (sda_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state_q)
                ST_DEV_ACK, ST_WADDR_ACK, ST_WDATA_ACK: begin
                    if (!ack_ph_q) begin
                        ack_ph_q <= 1'b1;
                        sda_oe_q <= (state_q == ST_WDATA_ACK) ? ~nack_q : 1'b1;
                    end else begin
                        ack_ph_q <= 1'b0;
                        bitcnt_q <= 3'd0;
                        if (state_q == ST_DEV_ACK && rw_q) begin
                            state_q  <= ST_RDATA;
                            shift_q  <= mem_q[ptr_q];
                            sda_oe_q <= ~mem_q[ptr_q][7];
                        end else begin
                            state_q  <= (state_q == ST_DEV_ACK) ? ST_WADDR : ST_WDATA;
                            sda_oe_q <= 1'b0;
                        end
                    end
                end
                ST_RDATA: sda_oe_q <= ~shift_q[7];
                ST_RACK: begin
                    if (!ack_ph_q) begin
                        ack_ph_q <= 1'b1;
                        sda_oe_q <= 1'b0;
                    end else begin
                        ack_ph_q <= 1'b0;
                        bitcnt_q <= 3'd0;
                        state_q  <= ST_RDATA;
                        ptr_q    <= ptr_nx;
                        shift_q  <= mem_q[ptr_nx];
                        sda_oe_q <= ~mem_q[ptr_nx][7];
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe = sda_oe_q;
    assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Self-checking bench for i2c_eeprom_slave: bit-banged I2C master plus a byte-array EEPROM model.
module tb_i2c_eeprom_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b1;
    logic m_sda = 1'b1;
    logic sda_oe;
    logic busy;
    logic sda_line;
`ifdef I2C_EEPROM_WP_EN
    logic wp = 1'b0;
`endif

    assign sda_line = m_sda & ~sda_oe;

    i2c_eeprom_slave dut (
        .clk    (clk),
        .rst    (rst),
`ifdef I2C_EEPROM_WP_EN
        .wp     (wp),
`endif
        .scl    (scl),
        .sda_in (sda_line),
        .sda_oe (sda_oe),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] mem_m [2048];
    int         ptr_m = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    logic       chk_en = 1'b0;
    logic       exp_oe = 1'b0;
    logic       exp_busy = 1'b0;
    logic [7:0] got_a [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Every SCL rise: slave outputs must match what the master expects from the model.
    always @(posedge scl) begin
        if (chk_en) begin
            chk("sda_oe@scl_rise", {31'd0, sda_oe}, {31'd0, exp_oe});
            chk("busy@scl_rise", {31'd0, busy}, {31'd0, exp_busy});
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] ctrl(input logic [10:0] a, input logic r);
        return {4'b1010, a[10:8], r};
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called with SCL just driven low; returns the line value sampled while SCL is high.
    task automatic bit_cycle(input logic b, input logic oe_exp, output logic rd);
        wait_clk(3); m_sda = b; exp_oe = oe_exp;
        wait_clk(5); scl = 1'b1;
        wait_clk(4); rd = sda_line;
        wait_clk(4); scl = 1'b0;
    endtask

    task automatic do_start();
        if (scl) begin
            wait_clk(4); m_sda = 1'b0;
            wait_clk(4); scl = 1'b0;
        end else begin
            wait_clk(3); m_sda = 1'b1; exp_oe = 1'b0;
            wait_clk(5); scl = 1'b1;
            wait_clk(4); m_sda = 1'b0;
            wait_clk(4); scl = 1'b0;
        end
        exp_busy = 1'b1;
    endtask

    task automatic do_stop();
        wait_clk(3); m_sda = 1'b0; exp_oe = 1'b0;
        wait_clk(5); scl = 1'b1;
        wait_clk(4); m_sda = 1'b1;
        wait_clk(8);
        exp_busy = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack_exp, input logic busy_at_ack);
        logic rd;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], 1'b0, rd);
        exp_busy = busy_at_ack;
        bit_cycle(1'b1, ack_exp, rd);
    endtask

    task automatic recv_byte(output logic [7:0] got, input logic m_ack);
        logic       rd;
        logic [7:0] exp_b;
        exp_b = mem_m[ptr_m];
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, ~exp_b[i], rd);
            got[i] = rd;
        end
        chk("read_byte", {24'd0, got}, {24'd0, exp_b});
        bit_cycle(~m_ack, 1'b0, rd);
        if (m_ack) ptr_m = (ptr_m + 1) % 2048;
        else exp_busy = 1'b0;
    endtask

    task automatic write_seq(input logic [10:0] addr, input logic [7:0] first, input int n,
                             input logic prot);
        logic [7:0] d;
        do_start();
        send_byte(ctrl(addr, 1'b0), 1'b1, 1'b1);
        send_byte(addr[7:0], 1'b1, 1'b1);
        ptr_m = int'(addr);
        for (int k = 0; k < n; k++) begin
            d = 8'(int'(first) + k);
            send_byte(d, ~prot, 1'b1);
            if (!prot) begin
                mem_m[ptr_m] = d;
                ptr_m = (ptr_m & ~15) | ((ptr_m + 1) & 15);
            end
        end
        do_stop();
    endtask

    task automatic read_rand(input logic [10:0] addr, input int n);
        do_start();
        send_byte(ctrl(addr, 1'b0), 1'b1, 1'b1);
        send_byte(addr[7:0], 1'b1, 1'b1);
        ptr_m = int'(addr);
        do_start();
        send_byte(ctrl(addr, 1'b1), 1'b1, 1'b1);
        for (int k = 0; k < n; k++) recv_byte(got_a[k], k < n - 1);
        do_stop();
    endtask

    task automatic read_cur(input int n);
        do_start();
        send_byte(ctrl(11'h000, 1'b1), 1'b1, 1'b1);
        for (int k = 0; k < n; k++) recv_byte(got_a[k], k < n - 1);
        do_stop();
    endtask

    initial begin
        logic rd;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(2);
        chk("reset_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk_en = 1'b1;

        // Byte write 0xA5 to 0x123, random read back.
        write_seq(11'h123, 8'hA5, 1, 1'b0);
        read_rand(11'h123, 1);
        chk("byte_write_readback", {24'd0, got_a[0]}, 32'h0000_00A5);

        // Page write of 18 bytes from 0x00E wraps inside page 0x000-0x00F; 0x010 untouched.
        write_seq(11'h010, 8'h77, 1, 1'b0);
        write_seq(11'h00E, 8'h00, 18, 1'b0);
        read_rand(11'h000, 17);
        chk("page_000", {24'd0, got_a[0]}, 32'h02);
        chk("page_00E", {24'd0, got_a[14]}, 32'h10);
        chk("page_00F", {24'd0, got_a[15]}, 32'h11);
        chk("page_010_kept", {24'd0, got_a[16]}, 32'h77);

        // Sequential read across the top of the array.
        write_seq(11'h7FE, 8'hC1, 2, 1'b0);
        read_rand(11'h7FE, 3);
        chk("seq_7FE", {24'd0, got_a[0]}, 32'hC1);
        chk("seq_7FF", {24'd0, got_a[1]}, 32'hC2);
        chk("seq_000", {24'd0, got_a[2]}, 32'h02);
        chk("seq_busy_after", {31'd0, busy}, 32'd0);

        // Device ID mismatch: no ACK, slave returns to idle.
        do_start();
        send_byte(8'b1011_0000, 1'b0, 1'b0);
        do_stop();
        chk("mismatch_busy", {31'd0, busy}, 32'd0);

        // STOP after 4 data bits must not write.
        do_start();
        send_byte(ctrl(11'h123, 1'b0), 1'b1, 1'b1);
        send_byte(8'h23, 1'b1, 1'b1);
        ptr_m = 32'h123;
        bit_cycle(1'b0, 1'b0, rd);
        bit_cycle(1'b1, 1'b0, rd);
        bit_cycle(1'b0, 1'b1 & 1'b0, rd);
        bit_cycle(1'b1, 1'b0, rd);
        do_stop();
        read_cur(1);
        chk("partial_no_write", {24'd0, got_a[0]}, 32'hA5);

        // Reset during RDATA: mem[0]=0x02, so bit 7 (0) is driven low first.
        do_start();
        send_byte(ctrl(11'h000, 1'b0), 1'b1, 1'b1);
        send_byte(8'h00, 1'b1, 1'b1);
        ptr_m = 0;
        do_start();
        send_byte(ctrl(11'h000, 1'b1), 1'b1, 1'b1);
        wait_clk(6);
        chk("rdata_bit7_driven", {31'd0, sda_oe}, 32'd1);
        chk_en = 1'b0;
        rst = 1'b1;
        wait_clk(1);
        chk("rst_mid_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        m_sda = 1'b1;
        wait_clk(2);
        scl = 1'b1;
        wait_clk(10);
        ptr_m = 0;
        exp_oe = 1'b0;
        exp_busy = 1'b0;
        chk_en = 1'b1;
        read_cur(1);
        chk("ptr_reset_read", {24'd0, got_a[0]}, 32'h02);

`ifdef I2C_EEPROM_WP_EN
        wp = 1'b1;
        write_seq(11'h010, 8'h5A, 1, 1'b1);
        wp = 1'b0;
        read_rand(11'h010, 1);
        chk("wp_old_value", {24'd0, got_a[0]}, 32'h77);
`endif

        wait_clk(10);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
